ftdi_tx_arbiter: RTL and testbench
==================================

# ftdi_tx_arbiter

Round-robin arbiter that shares the single TX stream of the FTDI 245-fifo control FSM between N independent stream sources. It sits between the user channels and the FSM's `tx_tvalid/tx_tready/tx_tdata/tx_tkeep` port. A grant is held for one burst, which ends on the source's `tlast` or after `MAX_BURST` beats. An optional header beat carrying the channel number is inserted before each burst so the host can demultiplex.

## Interface
- `CHIP_EW`, 0: data width selector. DW = 8<<CHIP_EW, KW = 1<<CHIP_EW.
- `N`, 4: number of sources, 2..16.
- `MAX_BURST`, 64: maximum data beats per grant, 1..65535.
- `INSERT_HEADER`, 1: 1 = emit a header beat before each burst.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rstn`  in  1  asynchronous active-low reset.
- `s_tvalid`  in  N  per-source valid.
- `s_tready`  out  N  per-source ready.
- `s_tdata`  in  N*DW  source i occupies bits [i*DW +: DW].
- `s_tkeep`  in  N*KW  source i occupies bits [i*KW +: KW].
- `s_tlast`  in  N  per-source end of packet.
- `m_tvalid`  out  1  to FSM `tx_tvalid`.
- `m_tready`  in  1  from FSM `tx_tready`.
- `m_tdata`  out  DW  to FSM `tx_tdata`.
- `m_tkeep`  out  KW  to FSM `tx_tkeep`.
- `m_tlast`  out  1  marks the final beat of the current grant.
- `grant`  out  4  index of the current or last granted channel.
- `busy`  out  1  1 when in S_HDR or S_DATA.

## Operation
- States: S_IDLE, S_HDR, S_DATA. The reset state is S_IDLE.
- **Priority pointer `last`:** resets to N-1, so channel 0 has first priority.
- **S_IDLE:**
  - If any `s_tvalid` is high, select the first asserted channel scanning (last+1), (last+2), … mod N.
  - Register the selection into `grant` and `last`, and clear the beat counter.
  - Go to S_HDR if INSERT_HEADER=1, else S_DATA.
  - The choice is made on the cycle it is registered; `s_tvalid` changes after that do not alter it.
- **S_HDR:**
  - Drive `m_tvalid`=1.
  - `m_tdata` = {DW-8 zeros, 4'hA, grant[3:0]}.
  - `m_tkeep` = all ones.
  - `m_tlast` = 0.
  - All `s_tready` = 0.
  - On `m_tready`=1, go to S_DATA.
- **S_DATA:**
  - `m_tvalid`, `m_tdata` and `m_tkeep` are the granted source's signals, combinationally muxed.
  - `s_tready[grant]` = `m_tready`; all other `s_tready` = 0.
  - A beat transfers when `m_tvalid & m_tready`.
  - `m_tlast` = `s_tlast[grant]` | (count == MAX_BURST-1).
  - Each transfer increments the count.
  - A transfer with `m_tlast`=1 returns the block to S_IDLE.
- **No preemption:** if the granted source drops `s_tvalid` mid-burst, the grant is held indefinitely with `m_tvalid`=0.
- **Burst limit:** the limit truncates a packet without consuming extra data. The remainder of the packet is sent on that channel's next grant, which also gets a new header.
- **Counter:** width is clog2(MAX_BURST+1). It never wraps, because it is reset at each grant.
- **Partial `tkeep`:** passed through unchanged. The FSM will leave its TX state afterwards; the arbiter does not treat this as a boundary.
- **Outputs in S_IDLE:** `m_tvalid`=0, `m_tdata`=0, `m_tkeep`=0, `m_tlast`=0, `s_tready`=0.
- **Reset values:**
  - State S_IDLE, `grant`=N-1, `busy`=0, counter 0.
  - All outputs take their S_IDLE values.
- **Reset mid-burst:** the burst is abandoned immediately. The source keeps its untransferred beat.

## Timing
- **Arbitration latency:** 1 cycle.
  - With `s_tvalid` high at edge k in S_IDLE, the header (or first data beat) is presented in cycle k+1.
- **Throughput:** one beat per cycle while `m_tready`=1 and the source is valid. There is no bubble between data beats.
- **Gap between grants:**
  - Exactly one S_IDLE cycle after the last beat.
  - Per-burst overhead is 1 idle cycle plus 1 header beat when INSERT_HEADER=1.
- **Combinational paths:**
  - `s_tready` depends combinationally on `m_tready`.
  - `m_tvalid` depends combinationally on `s_tvalid[grant]`.
  - There is no combinational path from `s_tvalid` to `grant`.
- **Simultaneous events:**
  - When the final beat transfers and a new `s_tvalid` rises in the same cycle, the new request is seen in the next S_IDLE cycle.
  - A channel that has just finished is scanned last.

## Test plan
- **Single channel:** N=4, channel 2 sends 3 beats (0x11, 0x22, 0x33 with tlast), `m_tready`=1.
  - Expected output: 0xA2, 0x11, 0x22, 0x33. `m_tlast` is high on 0x33 only; `grant`=2.
- **Round-robin:** all 4 channels continuously valid, 1-beat packets.
  - Expected header order: 0xA0, 0xA1, 0xA2, 0xA3, 0xA0.
  - Exactly 1 idle cycle between bursts.
- **Burst limit:** MAX_BURST=4, channel 1 sends a 10-beat packet while channel 3 is also valid.
  - Expected output: ch1 beats 0–3 (last flagged), then ch3's burst, then ch1 beats 4–7.
- **Backpressure:** `m_tready` toggles 1,0,1,0 during a burst.
  - No beat is duplicated or dropped.
  - `s_tready[grant]` mirrors `m_tready`; other `s_tready` stay 0.
- **Source stall:** the granted channel drops `s_tvalid` for 5 cycles mid-packet while others are valid.
  - The grant is unchanged, `m_tvalid`=0 during the stall, and the burst resumes afterwards.
- **Reset:** `rstn` is pulsed low during the 2nd data beat.
  - Outputs go to reset values asynchronously and `grant` = N-1.
  - After release, the first grant goes to the lowest valid channel scanning from 0.

Source files
------------

// File: rtl/ftdi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_tx_arbiter
// Purpose  : Round-robin burst arbiter sharing one FTDI 245-fifo TX stream
//            among N sources, with an optional channel header beat per burst.
// Revision : 1.0 - initial release
// ============================================================================
module ftdi_tx_arbiter #(
    parameter  int CHIP_EW       = 0,
    parameter  int N             = 4,
    parameter  int MAX_BURST     = 64,
    parameter  int INSERT_HEADER = 1,
    localparam int c_dw          = 8 << CHIP_EW,
    localparam int c_kw          = 1 << CHIP_EW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N-1:0]      s_tvalid,
    output logic [N-1:0]      s_tready,
    input  logic [N*c_dw-1:0] s_tdata,
    input  logic [N*c_kw-1:0] s_tkeep,
    input  logic [N-1:0]      s_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [c_dw-1:0]   m_tdata,
    output logic [c_kw-1:0]   m_tkeep,
    output logic              m_tlast,
    output logic [3:0]        grant,
    output logic              busy
);

    localparam int c_cw = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [c_cw-1:0]   count_q, count_d;

    logic [15:0]       w_vld16;
    logic [15:0]       w_lst16;
    logic [4:0]        w_cand;
    logic              w_found;
    logic [3:0]        w_sel;
    logic [c_dw-1:0]   w_src_data;
    logic [c_kw-1:0]   w_src_keep;
    logic              w_src_valid;
    logic              w_src_last;
    logic              w_burst_end;
    logic [N-1:0]      w_ready_sel;

    assign w_vld16     = 16'(s_tvalid);
    assign w_lst16     = 16'(s_tlast);
    assign w_src_valid = w_vld16[grant_q];
    assign w_src_last  = w_lst16[grant_q];
    assign w_burst_end = (count_q == c_cw'(MAX_BURST - 1));

    // grant_q doubles as the round-robin pointer: scan starts just past it.
    always_comb begin
        w_found = 1'b0;
        w_sel   = grant_q;
        w_cand  = 5'd0;
        for (int k = 1; k <= N; k++) begin
            w_cand = {1'b0, grant_q} + 5'(k);
            if (w_cand >= 5'(N)) begin
                w_cand = w_cand - 5'(N);
            end
            if (!w_found && w_vld16[w_cand[3:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[3:0];
            end
        end
    end

    always_comb begin
        w_src_data  = '0;
        w_src_keep  = '0;
        w_ready_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == 4'(i)) begin
                w_src_data     = s_tdata[i*c_dw +: c_dw];
                w_src_keep     = s_tkeep[i*c_kw +: c_kw];
                w_ready_sel[i] = m_tready;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        count_d  = count_q;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        s_tready = '0;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_d = w_sel;
                    count_d = '0;
                    state_d = (INSERT_HEADER != 0) ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = c_dw'({4'hA, grant_q});
                m_tkeep  = '1;
                if (m_tready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                m_tvalid = w_src_valid;
                m_tdata  = w_src_data;
                m_tkeep  = w_src_keep;
                m_tlast  = w_src_last | w_burst_end;
                s_tready = w_ready_sel;
                if (w_src_valid && m_tready) begin
                    count_d = count_q + 1'b1;
                    if (m_tlast) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            grant_q <= 4'(N - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            count_q <= count_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ftdi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ftdi_tx_arbiter
// Purpose  : Directed vector table plus multi-cycle stream sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ftdi_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 1;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [3:0]      grant;
    logic            busy;

    always #5 clk = ~clk;

    ftdi_tx_arbiter #(
        .CHIP_EW       (0),
        .N             (N),
        .MAX_BURST     (4),
        .INSERT_HEADER (1)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .grant    (grant),
        .busy     (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic [3:0]  lst;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic        ek;
        logic [3:0]  eg;
        logic [3:0]  er;
        logic        eb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [3:0] vld, input logic [31:0] dat,
                       input logic [3:0] lst, input logic rdy, input logic ev,
                       input logic [7:0] ed, input logic el, input logic ek,
                       input logic [3:0] eg, input logic [3:0] er, input logic eb);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dat = dat; v.lst = lst; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.el = el; v.ek = ek; v.eg = eg; v.er = er; v.eb = eb;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst m_tdata",  32'(m_tdata),  32'd0);
        check("rst grant",    32'(grant),    32'd3);
        check("rst busy",     32'(busy),     32'd0);
        check("rst s_tready", 32'(s_tready), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    logic [8:0] src_q [N][$];
    logic [8:0] exp_q [$];

    task automatic clear_q();
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    task automatic src(input int ch, input logic [7:0] d, input logic l);
        src_q[ch].push_back({l, d});
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    // Behavioural sources feed queued beats; every output transfer is scored in order.
    task automatic run_stream(input string name, input int rdy_mode,
                              input int stall_after, input int rst_at);
        int         got   = 0;
        int         pops0 = 0;
        int         stall = 0;
        bit         rst_done = 1'b0;
        bit         rel      = 1'b0;
        logic [3:0] v;
        logic [3:0] pop;
        for (int cyc = 0; cyc < 400 && got < exp_q.size(); cyc++) begin
            @(negedge clk);
            if (rel) begin
                rstn = 1'b1;
                rel  = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                v[i]             = (src_q[i].size() > 0) && !(i == 0 && stall > 0);
                s_tvalid[i]      = v[i];
                s_tdata[i*8 +: 8] = v[i] ? src_q[i][0][7:0] : 8'h00;
                s_tlast[i]       = v[i] ? src_q[i][0][8] : 1'b0;
            end
            m_tready = (rdy_mode == 1) ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (rst_at > 0 && !rst_done && got == rst_at && m_tvalid) begin
                rstn = 1'b0;
                #1;
                check({name, " async m_tvalid"}, 32'(m_tvalid), 32'd0);
                check({name, " async m_tdata"},  32'(m_tdata),  32'd0);
                check({name, " async grant"},    32'(grant),    32'd3);
                check({name, " async busy"},     32'(busy),     32'd0);
                check({name, " async s_tready"}, 32'(s_tready), 32'd0);
                rst_done = 1'b1;
                rel      = 1'b1;
            end
            if (stall > 0) begin
                check({name, " stall grant"},    32'(grant),    32'd0);
                check({name, " stall m_tvalid"}, 32'(m_tvalid), 32'd0);
                check({name, " stall busy"},     32'(busy),     32'd1);
                stall--;
            end
            if (m_tvalid) begin
                if (m_tdata[7:4] == 4'hA)
                    check({name, " hdr s_tready"}, 32'(s_tready), 32'd0);
                else
                    check({name, " data s_tready"}, 32'(s_tready),
                          32'({3'b000, m_tready} << grant));
            end
            if (m_tvalid && m_tready) begin
                check($sformatf("%s beat%0d", name, got), 32'({m_tlast, m_tdata}), 32'(exp_q[got]));
                check($sformatf("%s keep%0d", name, got), 32'(m_tkeep), 32'd1);
                got++;
            end
            pop = s_tready & v;
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (pop[i]) begin
                    void'(src_q[i].pop_front());
                    if (i == 0) begin
                        pops0++;
                        if (stall_after > 0 && pops0 == stall_after) stall = 5;
                    end
                end
            end
        end
        if (got < exp_q.size()) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0d beats, expected %0d", name, got, exp_q.size());
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn     = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '1;
        s_tlast  = '0;
        m_tready = 1'b0;

        // Single channel: ch2 sends 0x11,0x22,0x33(last)
        add(1, 4'b0100, 32'h0011_0000, 4'b0000, 1, 0, 8'h00, 0, 0, 4'd3, 4'b0000, 0);
        add(0, 4'b0100, 32'h0011_0000, 4'b0000, 1, 1, 8'hA2, 0, 1, 4'd2, 4'b0000, 1);
        add(0, 4'b0100, 32'h0011_0000, 4'b0000, 1, 1, 8'h11, 0, 1, 4'd2, 4'b0100, 1);
        add(0, 4'b0100, 32'h0022_0000, 4'b0000, 1, 1, 8'h22, 0, 1, 4'd2, 4'b0100, 1);
        add(0, 4'b0100, 32'h0033_0000, 4'b0100, 1, 1, 8'h33, 1, 1, 4'd2, 4'b0100, 1);
        add(0, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 8'h00, 0, 0, 4'd2, 4'b0000, 0);
        // Round robin: all channels valid with 1-beat packets
        add(1, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 0, 8'h00, 0, 0, 4'd3, 4'b0000, 0);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 1, 8'hA0, 0, 1, 4'd0, 4'b0000, 1);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 1, 8'hC0, 1, 1, 4'd0, 4'b0001, 1);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 0, 8'h00, 0, 0, 4'd0, 4'b0000, 0);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 1, 8'hA1, 0, 1, 4'd1, 4'b0000, 1);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 1, 8'hC1, 1, 1, 4'd1, 4'b0010, 1);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 0, 8'h00, 0, 0, 4'd1, 4'b0000, 0);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 1, 8'hA2, 0, 1, 4'd2, 4'b0000, 1);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 1, 8'hC2, 1, 1, 4'd2, 4'b0100, 1);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 0, 8'h00, 0, 0, 4'd2, 4'b0000, 0);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 1, 8'hA3, 0, 1, 4'd3, 4'b0000, 1);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 1, 8'hC3, 1, 1, 4'd3, 4'b1000, 1);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 0, 8'h00, 0, 0, 4'd3, 4'b0000, 0);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 1, 8'hA0, 0, 1, 4'd0, 4'b0000, 1);
        add(0, 4'b1111, 32'hC3C2_C1C0, 4'b1111, 1, 1, 8'hC0, 1, 1, 4'd0, 4'b0001, 1);

        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset();
            @(negedge clk);
            s_tvalid = tbl[k].vld;
            s_tdata  = tbl[k].dat;
            s_tlast  = tbl[k].lst;
            m_tready = tbl[k].rdy;
            #1;
            check($sformatf("vec%0d m_tvalid", k), 32'(m_tvalid), 32'(tbl[k].ev));
            check($sformatf("vec%0d m_tdata",  k), 32'(m_tdata),  32'(tbl[k].ed));
            check($sformatf("vec%0d m_tlast",  k), 32'(m_tlast),  32'(tbl[k].el));
            check($sformatf("vec%0d m_tkeep",  k), 32'(m_tkeep),  32'(tbl[k].ek));
            check($sformatf("vec%0d grant",    k), 32'(grant),    32'(tbl[k].eg));
            check($sformatf("vec%0d s_tready", k), 32'(s_tready), 32'(tbl[k].er));
            check($sformatf("vec%0d busy",     k), 32'(busy),     32'(tbl[k].eb));
        end

        // Burst limit of 4: ch1 10-beat packet interleaved with ch3
        do_reset();
        clear_q();
        for (int b = 0; b < 10; b++) src(1, 8'(8'h10 + b), b == 9);
        src(3, 8'h30, 1'b0);
        src(3, 8'h31, 1'b1);
        expect_beat(8'hA1, 0); expect_beat(8'h10, 0); expect_beat(8'h11, 0);
        expect_beat(8'h12, 0); expect_beat(8'h13, 1);
        expect_beat(8'hA3, 0); expect_beat(8'h30, 0); expect_beat(8'h31, 1);
        expect_beat(8'hA1, 0); expect_beat(8'h14, 0); expect_beat(8'h15, 0);
        expect_beat(8'h16, 0); expect_beat(8'h17, 1);
        expect_beat(8'hA1, 0); expect_beat(8'h18, 0); expect_beat(8'h19, 1);
        run_stream("burst", 0, 0, 0);

        // Backpressure: m_tready alternates
        do_reset();
        clear_q();
        for (int b = 0; b < 5; b++) src(2, 8'(8'h20 + b), b == 4);
        expect_beat(8'hA2, 0); expect_beat(8'h20, 0); expect_beat(8'h21, 0);
        expect_beat(8'h22, 0); expect_beat(8'h23, 1);
        expect_beat(8'hA2, 0); expect_beat(8'h24, 1);
        run_stream("bp", 1, 0, 0);

        // Source stall: ch0 goes quiet for 5 cycles after its 2nd beat
        do_reset();
        clear_q();
        for (int b = 0; b < 4; b++) src(0, 8'(8'h01 + b), b == 3);
        src(1, 8'h50, 1'b1);
        src(2, 8'h60, 1'b1);
        expect_beat(8'hA0, 0); expect_beat(8'h01, 0); expect_beat(8'h02, 0);
        expect_beat(8'h03, 0); expect_beat(8'h04, 1);
        expect_beat(8'hA1, 0); expect_beat(8'h50, 1);
        expect_beat(8'hA2, 0); expect_beat(8'h60, 1);
        run_stream("stall", 0, 2, 0);

        // Reset asserted while the 2nd data beat is presented
        do_reset();
        clear_q();
        src(1, 8'h71, 1'b0);
        src(1, 8'h72, 1'b0);
        src(1, 8'h73, 1'b1);
        src(3, 8'h91, 1'b1);
        expect_beat(8'hA1, 0); expect_beat(8'h71, 0);
        expect_beat(8'hA1, 0); expect_beat(8'h72, 0); expect_beat(8'h73, 1);
        run_stream("rst", 0, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
